maskable_cla_pipe: RTL
======================

// Module: maskable_cla_pipe
// PURPOSE
//  Downstream consumer of the four-bit carry-maskable half-adder slices: takes per-bit masked
//  propagate/generate terms, resolves carries with 4-bit lookahead groups, forms the final sum.
//  Two-stage registered pipeline with valid/ready handshake; sits between the operand
//  source and the approximate multiplier's partial-product accumulation.
//  Also flags whether the approximate result equals the exact sum.
// PARAMETERS
//  WIDTH  16  operand/sum width; must be a multiple of GROUP
//  GROUP  4   lookahead group size; carries ripple between groups
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      synchronous reset, active-low
//  in_valid   in   1      a/b/mask valid
//  in_ready   out  1      block can accept this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  mask       in   WIDTH  per-bit carry enable: 1 = exact bit, 0 = carry masked
//  out_valid  out  1      sum/cout/exact valid
//  out_ready  in   1      consumer accepts this cycle
//  sum        out  WIDTH  approximate sum
//  cout       out  1      carry out of MSB
//  exact      out  1      1 = result identical to exact a+b
// BEHAVIOUR
//  - One clock clk; reset synchronous, active-low (rst_n sampled on rising clk edge).
//  - Reset: s1_valid=0, out_valid=0, sum=0, cout=0, exact=0; in_ready=0 while rst_n=0.
//  - Transfer in on in_valid&in_ready; out on out_valid&out_ready.
//  - Stage 1 (registered on input transfer), per bit i:
//      mask[i]=1: p[i]=a[i]^b[i], g[i]=a[i]&b[i]
//      mask[i]=0: p[i]=a[i]|b[i], g[i]=0
//      hit = |(a&b&~mask)  (a masked bit would have generated a carry)
//  - Stage 2 (registered): carry-in to bit 0 = 0; within group c[i+1]=g[i]|p[i]&c[i] in
//    lookahead form; group carry-out feeds next group; sum[i]=p[i]^c[i]; cout=c[WIDTH];
//    exact = ~hit.
//  - Latency: 2 cycles from input transfer to out_valid with no backpressure.
//  - Throughput 1/cycle. s2_load = s1_valid & (~out_valid | out_ready);
//    in_ready = ~s1_valid | s2_load (combinational, ANDed with rst_n).
//  - Backpressure: out_ready=0 holds sum/cout/exact/out_valid stable; s1 holds while s2 full
//    and not draining; max 2 items in flight, in_ready drops when both stages full.
//  - Simultaneous out transfer and s1 advance in same cycle: s2 replaced, no bubble.
//  - Order preserved; no drops, no duplicates; out_valid never deasserts without transfer.
//  - Reset mid-operation: all in-flight items discarded; first post-reset input emerges 2
//    cycles after acceptance.
//  - mask all ones: result equals (a+b) mod 2^WIDTH, cout = bit WIDTH, exact=1 always.
//  - Data registers not reset-gated beyond stated reset values; no X on outputs post-reset.
// TESTING
//  1. a=16'h00FF b=16'h0001 mask=16'hFFFF -> sum=16'h0100 cout=0 exact=1, 2 cycles later.
//  2. a=16'h00FF b=16'h0001 mask=16'hFFFE -> sum=16'h00FF cout=0 exact=0.
//  3. a=16'hFFFF b=16'h0001 mask=16'hFFFF -> sum=16'h0000 cout=1 exact=1 (full carry chain
//     across all groups).
//  4. out_ready=0, present 3 back-to-back inputs -> first 2 accepted, in_ready=0 on 3rd,
//     outputs held stable; release out_ready -> 3 results in order, one per cycle.
//  5. 1000 random a/b/mask with random out_ready -> each result matches reference model
//     (masked p/g + CLA), in order; mask=FFFF subset matches a+b exactly.
//  6. rst_n=0 for one cycle with 2 items in flight -> out_valid=0 next cycle, no stale
//     result ever emitted, in_ready=1 after rst_n returns high.

Source files
------------

// File: rtl/maskable_cla_pipe.sv
// Two-stage valid/ready adder pipeline: masked propagate/generate per bit, then grouped
// carry lookahead with ripple between groups, plus a flag for agreement with the exact sum.
module maskable_cla_pipe #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] mask,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             exact
);

    localparam int unsigned NGROUPS = WIDTH / GROUP;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_p;
    logic [WIDTH-1:0] s1_g;
    logic             s1_hit;
    logic             s1_load;
    logic             s2_load;

    logic [WIDTH-1:0] p_c;
    logic [WIDTH-1:0] g_c;
    logic             hit_c;
    logic [WIDTH-1:0] carry_c;
    logic             carry_out_c;
    logic [GROUP:0]   grp_c;
    logic             cin_c;

    // Carries of one group in flattened lookahead form: c[k+1] = g[k] | p[k]g[k-1] | ... | p[k..0]cin
    function automatic logic [GROUP:0] cla_group(input logic [GROUP-1:0] gp,
                                                 input logic [GROUP-1:0] gg,
                                                 input logic             cin);
        logic [GROUP:0] c;
        logic           t;
        c    = '0;
        c[0] = cin;
        for (int k = 0; k < int'(GROUP); k++) begin
            t = cin;
            for (int j = 0; j <= k; j++) t = t & gp[j];
            c[k+1] = t;
            for (int j = 0; j <= k; j++) begin
                t = gg[j];
                for (int m = j + 1; m <= k; m++) t = t & gp[m];
                c[k+1] = c[k+1] | t;
            end
        end
        return c;
    endfunction

    assign s2_load  = s1_valid & (~out_valid | out_ready);
    assign in_ready = rst_n & (~s1_valid | s2_load);
    assign s1_load  = in_valid & in_ready;

    // Masked bits keep their propagate path but never generate
    assign p_c   = (mask & (a ^ b)) | (~mask & (a | b));
    assign g_c   = mask & a & b;
    assign hit_c = |(a & b & ~mask);

    always_comb begin
        carry_c = '0;
        grp_c   = '0;
        cin_c   = 1'b0;
        for (int gi = 0; gi < int'(NGROUPS); gi++) begin
            grp_c = cla_group(s1_p[gi*GROUP +: GROUP], s1_g[gi*GROUP +: GROUP], cin_c);
            carry_c[gi*GROUP +: GROUP] = grp_c[GROUP-1:0];
            cin_c = grp_c[GROUP];
        end
        carry_out_c = cin_c;
    end

    // Stage 1 data carries no reset value; s1_valid qualifies it
    always_ff @(posedge clk) begin
        if (s1_load) begin
            s1_p   <= p_c;
            s1_g   <= g_c;
            s1_hit <= hit_c;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            exact     <= 1'b0;
        end else begin
            if (s1_load)      s1_valid <= 1'b1;
            else if (s2_load) s1_valid <= 1'b0;

            if (s2_load) begin
                out_valid <= 1'b1;
                sum       <= s1_p ^ carry_c;
                cout      <= carry_out_c;
                exact     <= ~s1_hit;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
